td4_regs: RTL and testbench

TD4_REGS -- requirements
Module: td4_regs

---
 rtl/td4_regs.sv | 105 ++++++++++
 tb/tb_td4_regs.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/td4_regs.sv
// TD4 register file: registers A/B/OUT/PC and the carry flag, updated on an
// execute strobe from a run-mode clock divider or a debounced manual step.
module td4_regs #(
  parameter int unsigned DIV_SLOW = 12000000,
  parameter int unsigned DIV_FAST = 1200000,
  parameter int unsigned CNT_W    = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       fast,
  input  logic       step,
  input  logic [3:0] ld_n,
  input  logic [3:0] d,
  input  logic       cy_in,
  input  logic [3:0] in_port,
  output logic [3:0] reg_a,
  output logic [3:0] reg_b,
  output logic [3:0] in_sync,
  output logic [3:0] out_port,
  output logic [3:0] pc,
  output logic       c_flag,
  output logic       tick
);

  localparam logic [CNT_W-1:0] LAST_SLOW = CNT_W'(DIV_SLOW - 1);
  localparam logic [CNT_W-1:0] LAST_FAST = CNT_W'(DIV_FAST - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d, last_s;
  logic             run_q;
  logic             tick_q, tick_d;
  logic [2:0]       stp_q;
  logic [3:0]       in_s1_q, in_s2_q;
  logic [3:0]       a_q, b_q, out_q, pc_q;
  logic             c_q;

  // Divider next state; an overshoot after a rate change parks the count on
  // the new terminal value so exactly one tick is still produced.
  always_comb begin
    last_s = fast ? LAST_FAST : LAST_SLOW;
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (run != run_q) begin
      cnt_d  = '0;
      tick_d = 1'b0;
    end else if (!run) begin
      cnt_d  = '0;
      tick_d = stp_q[1] & ~stp_q[2];
    end else begin
      if (tick_q) begin
        cnt_d = '0;
      end else if (cnt_q >= last_s) begin
        cnt_d = last_s;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
      tick_d = (cnt_d == last_s);
    end
  end

  // Timing, synchronizers and architectural registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      run_q   <= 1'b0;
      tick_q  <= 1'b0;
      stp_q   <= 3'b111;
      in_s1_q <= 4'h0;
      in_s2_q <= 4'h0;
      a_q     <= 4'h0;
      b_q     <= 4'h0;
      out_q   <= 4'h0;
      pc_q    <= 4'h0;
      c_q     <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      run_q   <= run;
      tick_q  <= tick_d;
      stp_q   <= {stp_q[1], stp_q[0], step};
      in_s1_q <= in_port;
      in_s2_q <= in_s1_q;
      if (tick_q) begin
        if (!ld_n[0]) a_q   <= d;
        if (!ld_n[1]) b_q   <= d;
        if (!ld_n[2]) out_q <= d;
        if (!ld_n[3]) begin
          pc_q <= d;
        end else begin
          pc_q <= pc_q + 4'd1;
        end
        c_q <= cy_in;
      end
    end
  end

  assign reg_a    = a_q;
  assign reg_b    = b_q;
  assign out_port = out_q;
  assign pc       = pc_q;
  assign c_flag   = c_q;
  assign tick     = tick_q;
  assign in_sync  = in_s2_q;

endmodule

// File: tb/tb_td4_regs.sv
// Directed bench for td4_regs with a short divider (10 slow, 3 fast).
module tb_td4_regs;

  logic       clk = 1'b0;
  logic       rst_n, run, fast, step, cy_in;
  logic [3:0] ld_n, d, in_port;
  logic [3:0] reg_a, reg_b, in_sync, out_port, pc;
  logic       c_flag, tick;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_pc;
  int n, tk, first;

  td4_regs #(.DIV_SLOW(10), .DIV_FAST(3), .CNT_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .fast(fast), .step(step),
    .ld_n(ld_n), .d(d), .cy_in(cy_in), .in_port(in_port),
    .reg_a(reg_a), .reg_b(reg_b), .in_sync(in_sync), .out_port(out_port),
    .pc(pc), .c_flag(c_flag), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Cycles until tick is seen; -1 when the budget runs out.
  task automatic wait_tick(input int budget, output int cnt);
    cnt = 0;
    do begin
      cyc();
      cnt++;
    end while (tick !== 1'b1 && cnt < budget);
    if (tick !== 1'b1) cnt = -1;
  endtask

  task automatic clk_count(input int len, output int ticks, output int first_at);
    ticks = 0;
    first_at = 0;
    for (int i = 1; i <= len; i++) begin
      cyc();
      if (tick === 1'b1) begin
        ticks++;
        if (first_at == 0) first_at = i;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no end expected end");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; run = 1'b1; fast = 1'b0; step = 1'b0;
    ld_n = 4'hF; d = 4'h0; cy_in = 1'b0; in_port = 4'h0;
    repeat (3) cyc();
    check("reset_state", {reg_a, reg_b, out_port, pc, c_flag, tick, in_sync}, 32'd0);

    rst_n = 1'b1;
    wait_tick(30, n);
    check("first_tick", n, 10);
    check("pc_first", pc, 0);
    exp_pc = 1;
    for (int k = 1; k <= 16; k++) begin
      wait_tick(30, n);
      check("slow_period", n, 10);
      check("pc_count", pc, exp_pc);
      exp_pc = (exp_pc + 1) % 16;
    end

    // Switch to fast while the count (5) is past the new terminal value (2).
    repeat (6) cyc();
    fast = 1'b1;
    wait_tick(30, n);
    check("fast_switch", n, 1);
    check("pc_switch", pc, exp_pc);
    exp_pc = (exp_pc + 1) % 16;
    for (int k = 0; k < 2; k++) begin
      wait_tick(30, n);
      check("fast_period", n, 3);
      check("pc_fast", pc, exp_pc);
      exp_pc = (exp_pc + 1) % 16;
    end

    // Load A with carry during the current tick cycle.
    ld_n = 4'b1110; d = 4'h9; cy_in = 1'b1;
    cyc();
    ld_n = 4'b0000; d = 4'hF; cy_in = 1'b0;
    check("load_a", reg_a, 9);
    check("load_c", c_flag, 1);
    check("load_pc_inc", pc, exp_pc);
    cyc();
    ld_n = 4'hF;
    check("hold_a", reg_a, 9);
    check("hold_pc", {pc, c_flag, reg_b, out_port}, {exp_pc[3:0], 1'b1, 4'h0, 4'h0});

    wait_tick(10, n);
    check("tick_after_hold", n, 1);
    ld_n = 4'b0111; d = 4'hC; cy_in = 1'b0;
    cyc();
    ld_n = 4'hF;
    check("load_pc", pc, 12);
    check("load_c0", c_flag, 0);

    wait_tick(10, n);
    check("pc_before_multi", pc, 12);
    ld_n = 4'b1000; d = 4'h5;
    cyc();
    ld_n = 4'hF; d = 4'h0;
    check("multi_abo", {reg_a, reg_b, out_port}, {4'h5, 4'h5, 4'h5});
    check("multi_pc", pc, 13);

    in_port = 4'hA;
    cyc();
    check("in_sync_1clk", in_sync, 0);
    cyc();
    check("in_sync_2clk", in_sync, 4'hA);
    check("in_no_a", reg_a, 5);

    // Count sits at 2 now: tick is active; leave run mode across it.
    check("tick_before_step", tick, 1);
    exp_pc = 14;
    run = 1'b0;
    repeat (3) cyc();
    check("pc_enter_step", pc, exp_pc);

    for (int p = 0; p < 2; p++) begin
      step = 1'b1;
      clk_count(20, tk, first);
      check("step_ticks", tk, 1);
      check("step_latency", first, 3);
      step = 1'b0;
      clk_count(10, tk, first);
      check("step_low_ticks", tk, 0);
      exp_pc = (exp_pc + 1) % 16;
    end
    check("pc_after_step", pc, exp_pc);

    run = 1'b1; step = 1'b1;
    clk_count(15, tk, first);
    check("run_step_hi", tk, 5);
    check("run_first", first, 3);
    step = 1'b0;
    clk_count(15, tk, first);
    check("run_step_lo", tk, 5);
    cyc();
    exp_pc = (exp_pc + 10) % 16;
    check("pc_run_fast", pc, exp_pc);

    // Reset at count 7 in slow mode with step held high.
    run = 1'b0;
    cyc();
    fast = 1'b0; step = 1'b1; run = 1'b1;
    repeat (8) cyc();
    check("no_tick_at_7", tick, 0);
    rst_n = 1'b0;
    #1;
    check("reset_async", {reg_a, reg_b, out_port, pc, c_flag, tick, in_sync}, 32'd0);
    repeat (3) cyc();
    check("reset_hold", {pc, tick, in_sync}, 32'd0);
    rst_n = 1'b1;
    wait_tick(30, n);
    check("tick_after_reset", n, 10);
    check("pc_after_reset", pc, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
